keysearch_scheduler: RTL and testbench

Schedules the RC4 key-space search across NUM_CORES parallel decryption cores. Splits [0, KEY_LIMIT] into fixed-size chunks and hands each chunk to an idle core, using a round-robin grant with a registered req/grant handshake. Tracks chunks still in flight, stops every core as soon as one reports a valid key, and latches the winning key and core index for the top-level HEX/LED display.

---
 rtl/keysearch_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_keysearch_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keysearch_scheduler.sv
// rtl/keysearch_scheduler.sv - RC4 key-space chunk dispatcher with round-robin grant and found/exhausted latch
// Optional: define KEYSEARCH_PERF_EN to add the search_cycles counter output.
module keysearch_scheduler #(
   parameter int                   NUM_CORES  = 5,
   parameter int                   KEY_WIDTH  = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_LIMIT  = 24'h3FFFFF,
   parameter logic [KEY_WIDTH-1:0] CHUNK_SIZE = 24'h010000,
   parameter int                   IDX_W      = $clog2(NUM_CORES)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [NUM_CORES-1:0]           core_req,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES-1:0]           core_found,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   output logic [NUM_CORES-1:0]           core_grant,
   output logic [KEY_WIDTH-1:0]           chunk_base,
   output logic [KEY_WIDTH-1:0]           chunk_last,
   output logic                           core_abort,
   output logic                           busy,
   output logic                           found,
   output logic                           exhausted,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [IDX_W-1:0]               found_core
`ifdef KEYSEARCH_PERF_EN
   ,
   output logic [31:0]                    search_cycles
`endif
);

   localparam int CNT_W = $clog2(NUM_CORES + 1);
   localparam int OS_W  = CNT_W + 1;
   localparam int NB_W  = KEY_WIDTH + 1;
   localparam logic [NB_W-1:0] LIMIT_X = {1'b0, KEY_LIMIT};
   localparam logic [NB_W-1:0] CHUNK_X = {1'b0, CHUNK_SIZE};

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISPATCH,
      S_DRAIN,
      S_FOUND,
      S_EXHAUSTED
   } state_t;

   state_t                 state, state_nxt;
   logic [NB_W-1:0]        next_base, next_base_nxt;
   logic [CNT_W-1:0]       outstanding, outstanding_nxt;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [NUM_CORES-1:0]   last_grant_mask, last_grant_mask_nxt;
   logic [NUM_CORES-1:0]   grant_nxt;
   logic [KEY_WIDTH-1:0]   chunk_base_nxt, chunk_last_nxt, found_key_nxt;
   logic [IDX_W-1:0]       found_core_nxt;

   logic [NUM_CORES-1:0]   eligible;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       finder_idx;
   logic [KEY_WIDTH-1:0]   finder_key;
   logic [CNT_W-1:0]       done_cnt;
   logic [NB_W-1:0]        chunk_end;
   logic [OS_W-1:0]        out_sum;
   logic                   start_ok;

   assign busy       = (state == S_DISPATCH) || (state == S_DRAIN);
   assign found      = (state == S_FOUND);
   assign exhausted  = (state == S_EXHAUSTED);
   assign core_abort = found || exhausted;
   assign start_ok   = start && !busy;

   // Round-robin: first eligible core at or above rr_ptr, otherwise wrap to the lowest.
   always_comb begin
      eligible   = core_req & ~last_grant_mask;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
         if (!pick_valid && eligible[c] && (IDX_W'(c) >= rr_ptr)) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(c);
         end
      end
      for (int c = 0; c < NUM_CORES; c++) begin
         if (!pick_valid && eligible[c]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(c);
         end
      end
   end

   // Lowest-index finder wins when several cores report in the same cycle.
   always_comb begin
      finder_idx = '0;
      finder_key = '0;
      done_cnt   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_found[i]) begin
            finder_idx = IDX_W'(i);
            finder_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         done_cnt = done_cnt + CNT_W'(core_done[i]);
      end
   end

   assign chunk_end = next_base + CHUNK_X - NB_W'(1);

   always_comb begin
      state_nxt           = state;
      next_base_nxt       = next_base;
      outstanding_nxt     = outstanding;
      rr_ptr_nxt          = rr_ptr;
      last_grant_mask_nxt = '0;
      grant_nxt           = '0;
      chunk_base_nxt      = chunk_base;
      chunk_last_nxt      = chunk_last;
      found_key_nxt       = found_key;
      found_core_nxt      = found_core;
      out_sum             = '0;

      case (state)
         S_DISPATCH: begin
            if (|core_found) begin
               state_nxt      = S_FOUND;
               found_key_nxt  = finder_key;
               found_core_nxt = finder_idx;
            end else if (next_base > LIMIT_X) begin
               state_nxt = S_DRAIN;
            end else if (pick_valid) begin
               grant_nxt[pick_idx]           = 1'b1;
               last_grant_mask_nxt[pick_idx] = 1'b1;
               chunk_base_nxt = next_base[KEY_WIDTH-1:0];
               chunk_last_nxt = (chunk_end > LIMIT_X) ? KEY_LIMIT : chunk_end[KEY_WIDTH-1:0];
               next_base_nxt  = next_base + CHUNK_X;
               rr_ptr_nxt     = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            if (|core_found) begin
               state_nxt      = S_FOUND;
               found_key_nxt  = finder_key;
               found_core_nxt = finder_idx;
            end else if (outstanding == '0) begin
               state_nxt = S_EXHAUSTED;
            end
         end
         default: begin
            if (start) begin
               state_nxt      = S_DISPATCH;
               next_base_nxt  = '0;
               rr_ptr_nxt     = '0;
               found_key_nxt  = '0;
               found_core_nxt = '0;
            end
         end
      endcase

      // Grant and done in one cycle net out; done with nothing in flight saturates at zero.
      if (busy) begin
         out_sum = OS_W'(outstanding) + OS_W'(|grant_nxt);
         if (out_sum >= OS_W'(done_cnt)) outstanding_nxt = CNT_W'(out_sum - OS_W'(done_cnt));
         else                            outstanding_nxt = '0;
      end else if (start) begin
         outstanding_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         next_base       <= '0;
         outstanding     <= '0;
         rr_ptr          <= '0;
         last_grant_mask <= '0;
         core_grant      <= '0;
         chunk_base      <= '0;
         chunk_last      <= '0;
         found_key       <= '0;
         found_core      <= '0;
      end else begin
         state           <= state_nxt;
         next_base       <= next_base_nxt;
         outstanding     <= outstanding_nxt;
         rr_ptr          <= rr_ptr_nxt;
         last_grant_mask <= last_grant_mask_nxt;
         core_grant      <= grant_nxt;
         chunk_base      <= chunk_base_nxt;
         chunk_last      <= chunk_last_nxt;
         found_key       <= found_key_nxt;
         found_core      <= found_core_nxt;
      end
   end

`ifdef KEYSEARCH_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                search_cycles <= '0;
      else if (start_ok)                           search_cycles <= '0;
      else if (busy && (search_cycles != '1))      search_cycles <= search_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_keysearch_scheduler.sv
// tb/tb_keysearch_scheduler.sv - directed and randomized bench for keysearch_scheduler against a chunk-level model
module tb_keysearch_scheduler;

   localparam int N     = 5;
   localparam int KW    = 24;
   localparam int IW    = 3;
   localparam int LIM_A = 'h3FF;
   localparam int CH_A  = 'h100;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic            a_start, b_start;
   logic [N-1:0]    a_req, a_done, a_found, b_req, b_done, b_found;
   logic [N*KW-1:0] a_key, b_key;
   logic [N-1:0]    a_grant, b_grant;
   logic [KW-1:0]   a_base, a_last, a_fkey, b_base, b_last, b_fkey;
   logic            a_abort, a_busy, a_fnd, a_exh, b_abort, b_busy, b_fnd, b_exh;
   logic [IW-1:0]   a_fcore, b_fcore;
`ifdef KEYSEARCH_PERF_EN
   logic [31:0]     a_cyc, b_cyc;
`endif

   keysearch_scheduler #(.NUM_CORES(N), .KEY_WIDTH(KW), .KEY_LIMIT(24'h3FF), .CHUNK_SIZE(24'h100)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .core_req(a_req), .core_done(a_done),
      .core_found(a_found), .core_key(a_key), .core_grant(a_grant), .chunk_base(a_base),
      .chunk_last(a_last), .core_abort(a_abort), .busy(a_busy), .found(a_fnd),
      .exhausted(a_exh), .found_key(a_fkey), .found_core(a_fcore)
`ifdef KEYSEARCH_PERF_EN
      , .search_cycles(a_cyc)
`endif
   );

   keysearch_scheduler #(.NUM_CORES(N), .KEY_WIDTH(KW), .KEY_LIMIT(24'h2FF), .CHUNK_SIZE(24'h200)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .core_req(b_req), .core_done(b_done),
      .core_found(b_found), .core_key(b_key), .core_grant(b_grant), .chunk_base(b_base),
      .chunk_last(b_last), .core_abort(b_abort), .busy(b_busy), .found(b_fnd),
      .exhausted(b_exh), .found_key(b_fkey), .found_core(b_fcore)
`ifdef KEYSEARCH_PERF_EN
      , .search_cycles(b_cyc)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // model of dut_a: phase 0 idle, 1 dispatch, 2 drain, 3 found, 4 exhausted
   int ph = 0;
   int m_next, m_out, m_rr, m_last;
   int exp_fkey = 0, exp_fcore = 0;
   int cyc_no = 0;

   // stimulus-side core model
   int c_left[N];
   bit c_linger[N];
   bit c_find[N];
   int c_key[N];
   int gcyc[N];

   bit           directed;
   bit           d_start;
   logic [N-1:0] d_req, d_done, d_found;
   int           d_key[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      ph = 0; m_next = 0; m_out = 0; m_rr = 0; m_last = -1;
      exp_fkey = 0; exp_fcore = 0;
      for (int i = 0; i < N; i++) begin
         c_left[i] = 0; c_linger[i] = 0; c_find[i] = 0; c_key[i] = 0; gcyc[i] = -100;
      end
   endtask

   task automatic cycle_a();
      logic [N-1:0]    req, done, fnd;
      logic [N*KW-1:0] keys;
      int g = -1;
      int e_base = 0, e_last = 0, nph, c;
      keys = '0;
      if (directed) begin
         req = d_req; done = d_done; fnd = d_found;
         for (int i = 0; i < N; i++) keys[i*KW +: KW] = KW'(d_key[i]);
      end else begin
         req = '0; done = '0; fnd = '0;
         for (int i = 0; i < N; i++) begin
            keys[i*KW +: KW] = KW'($urandom);
            req[i] = (c_left[i] == 0 && $urandom_range(0, 3) != 0) || c_linger[i];
            if (c_left[i] > 0) begin
               c_left[i]--;
               if (c_left[i] == 0) begin
                  if (c_find[i]) begin
                     fnd[i] = 1'b1;
                     keys[i*KW +: KW] = KW'(c_key[i]);
                  end else begin
                     done[i] = 1'b1;
                  end
               end
            end else if ($urandom_range(0, 49) == 0) begin
               done[i] = 1'b1;
            end
         end
      end

      nph = ph;
      if (ph == 1 || ph == 2) begin
         if (fnd != '0) begin
            nph = 3;
            for (int k = N - 1; k >= 0; k--)
               if (fnd[k]) begin exp_fcore = k; exp_fkey = int'(keys[k*KW +: KW]); end
         end else if (ph == 1 && m_next > LIM_A) begin
            nph = 2;
         end else if (ph == 1) begin
            for (int k = 0; k < N; k++) begin
               c = (m_rr + k) % N;
               if (g < 0 && req[c] && c != m_last) g = c;
            end
         end else if (m_out == 0) begin
            nph = 4;
         end
         m_last = g;
         if (g >= 0) begin
            e_base = m_next;
            e_last = (m_next + CH_A - 1 > LIM_A) ? LIM_A : m_next + CH_A - 1;
            m_next += CH_A;
            m_rr = (g + 1) % N;
         end
         m_out = m_out + ((g >= 0) ? 1 : 0) - $countones(done);
         if (m_out < 0) m_out = 0;
      end else if (d_start) begin
         nph = 1; m_next = 0; m_out = 0; m_rr = 0; m_last = -1;
         exp_fkey = 0; exp_fcore = 0;
      end

      a_start = d_start; a_req = req; a_done = done; a_found = fnd; a_key = keys;
      d_start = 1'b0;
      @(posedge clk);
      #1;
      cyc_no++;
      ph = nph;

      chk("grant", 32'(a_grant), (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
         chk("chunk_base", 32'(a_base), e_base);
         chk("chunk_last", 32'(a_last), e_last);
         gcyc[g] = cyc_no;
      end
      chk("busy", 32'(a_busy), 32'(ph == 1 || ph == 2));
      chk("found", 32'(a_fnd), 32'(ph == 3));
      chk("exhausted", 32'(a_exh), 32'(ph == 4));
      chk("abort", 32'(a_abort), 32'(ph == 3 || ph == 4));
      if (ph == 3) begin
         chk("found_key", 32'(a_fkey), exp_fkey);
         chk("found_core", 32'(a_fcore), exp_fcore);
      end

      for (int i = 0; i < N; i++) c_linger[i] = 1'b0;
      if (!directed && g >= 0) begin
         c_left[g]   = $urandom_range(2, 12);
         c_linger[g] = 1'($urandom_range(0, 1));
         c_find[g]   = ($urandom_range(0, 5) == 0);
         c_key[g]    = $urandom_range(e_last, e_base);
      end
      if (ph == 3 || ph == 4)
         for (int i = 0; i < N; i++) c_left[i] = 0;
   endtask

   task automatic reset_pulse();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_grant", 32'(a_grant), 0);
      chk("rst_base", 32'(a_base), 0);
      chk("rst_last", 32'(a_last), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_abort", 32'(a_abort), 0);
      chk("rst_found", 32'(a_fnd), 0);
      chk("rst_exh", 32'(a_exh), 0);
      chk("rst_fkey", 32'(a_fkey), 0);
      chk("rst_fcore", 32'(a_fcore), 0);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      a_start = 0; a_req = 0; a_done = 0; a_found = 0; a_key = 0;
      b_start = 0; b_req = 0; b_done = 0; b_found = 0; b_key = 0;
      directed = 1; d_start = 0; d_req = 0; d_done = 0; d_found = 0;
      for (int i = 0; i < N; i++) d_key[i] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(a_busy), 0);
      chk("reset_abort", 32'(a_abort), 0);
      chk("reset_grant", 32'(a_grant), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_exh", 32'(a_exh), 0);
      chk("b_idle_grant", 32'(b_grant), 0);

      // dut_b: truncated last chunk
      b_start = 1; b_req = '1;
      @(posedge clk); #1 b_start = 0;
      chk("b_start_grant", 32'(b_grant), 0);
      chk("b_busy", 32'(b_busy), 1);
      @(posedge clk); #1;
      chk("b_g0", 32'(b_grant), 1);
      chk("b_base0", 32'(b_base), 'h000);
      chk("b_last0", 32'(b_last), 'h1FF);
      @(posedge clk); #1;
      chk("b_g1", 32'(b_grant), 2);
      chk("b_base1", 32'(b_base), 'h200);
      chk("b_last1", 32'(b_last), 'h2FF);
      repeat (2) begin
         @(posedge clk); #1;
         chk("b_no_third_grant", 32'(b_grant), 0);
      end
      b_req = 0; b_done = 5'b00011;
      @(posedge clk); #1 b_done = 0;
      @(posedge clk); #1;
      chk("b_exh", 32'(b_exh), 1);
      chk("b_abort", 32'(b_abort), 1);

      // dut_a: four consecutive grants then drain, then timed dones to exhaustion
      d_start = 1; d_req = '1;
      cycle_a();
      for (int k = 0; k < 4; k++) begin
         cycle_a();
         chk("t1_grant", 32'(a_grant), 1 << k);
         chk("t1_base", 32'(a_base), k * 'h100);
         chk("t1_last", 32'(a_last), k * 'h100 + 'hFF);
      end
      cycle_a();
      chk("t1_drain_grant", 32'(a_grant), 0);
      chk("t1_drain_busy", 32'(a_busy), 1);
      d_req = 0;
      for (int t = 0; t < 25; t++) begin
         for (int k = 0; k < N; k++) d_done[k] = (cyc_no + 1 == gcyc[k] + 10);
         cycle_a();
      end
      d_done = 0;
      chk("t2_exh", 32'(a_exh), 1);
      chk("t2_abort", 32'(a_abort), 1);
      chk("t2_found", 32'(a_fnd), 0);

      // simultaneous finders; start ignored while busy; later finder ignored
      d_start = 1; d_req = '1;
      cycle_a();
      cycle_a();
      d_start = 1;
      cycle_a();
      chk("t3_start_ignored", 32'(a_grant), 2);
      d_found = 5'b01010; d_key[3] = 'h1A2; d_key[1] = 'h0B7;
      cycle_a();
      chk("t3_no_grant", 32'(a_grant), 0);
      chk("t3_found", 32'(a_fnd), 1);
      chk("t3_fcore", 32'(a_fcore), 1);
      chk("t3_fkey", 32'(a_fkey), 'h0B7);
      d_found = 0;
      cycle_a();
      d_found = 5'b10000; d_key[4] = 'h3AA;
      cycle_a();
      d_found = 0; d_req = 0;
      cycle_a();
      chk("t3_hold_key", 32'(a_fkey), 'h0B7);
      chk("t3_hold_core", 32'(a_fcore), 1);

      // rr_ptr=2 with cores 1 and 4 requesting
      d_start = 1; d_req = 0;
      cycle_a();
      d_req = 5'b00010;
      cycle_a();
      chk("t4_first", 32'(a_grant), 5'b00010);
      d_req = 0;
      cycle_a();
      d_req = 5'b10010;
      cycle_a();
      chk("t4_core4", 32'(a_grant), 5'b10000);
      cycle_a();
      chk("t4_core1", 32'(a_grant), 5'b00010);
      chk("t4_base", 32'(a_base), 'h200);

      // async reset mid-dispatch with three chunks in flight, then clean restart
      reset_pulse();
      d_start = 1; d_req = '1;
      cycle_a();
      cycle_a();
      chk("t5_grant", 32'(a_grant), 1);
      chk("t5_base", 32'(a_base), 0);
      chk("t5_last", 32'(a_last), 'hFF);
      reset_pulse();

      // randomized searches against the model
      directed = 0;
      for (int s = 0; s < 30; s++) begin
         d_start = 1;
         cycle_a();
         for (int t = 0; t < 300 && (ph == 1 || ph == 2); t++) begin
            d_start = ($urandom_range(0, 39) == 0);
            cycle_a();
         end
         chk("search_end", 32'(a_abort), 1);
         repeat (2) cycle_a();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
